// File: rtl/dt_pack.sv
// Reads the 8-bit distance map back from res RAM, thresholds each pixel and
// packs 16 pixels per word (MSB = first pixel) into the sti-format output RAM.
module dt_pack #(
  parameter int NWORDS  = 1024,
  parameter int DEPTH_W = 14,
  parameter int OADDR_W = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [7:0]         thr,
  output logic               res_rd,
  output logic [DEPTH_W-1:0] res_addr,
  input  logic [7:0]         res_di,
  output logic               out_wr,
  output logic [OADDR_W-1:0] out_addr,
  output logic [15:0]        out_do,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_TAIL  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [OADDR_W-1:0] LAST_WORD = OADDR_W'(NWORDS - 1);
  localparam logic [DEPTH_W-1:0] ADDR_ONE  = DEPTH_W'(1);
  localparam logic [3:0]         LAST_K    = 4'd15;

  state_t               state, state_nx;
  logic [3:0]           k, k_nx;
  logic [OADDR_W-1:0]   word, word_nx;
  logic [7:0]           thr_q, thr_nx;
  logic [15:0]          sh_p1, sh_nx;
  logic                 hit_p0;

  logic                 rd_nx;
  logic [DEPTH_W-1:0]   raddr_nx;
  logic                 wr_nx;
  logic [OADDR_W-1:0]   oaddr_nx;
  logic [15:0]          do_nx;
  logic                 busy_nx;
  logic                 done_nx;

  // A zero threshold is treated as one, so the mask never includes background.
  function automatic logic pix_hit(input logic [7:0] d, input logic [7:0] t);
    logic [7:0] te;
    te = (t == 8'd0) ? 8'd1 : t;
    return (d >= te);
  endfunction

  assign hit_p0 = pix_hit(res_di, thr_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      k        <= 4'd0;
      word     <= '0;
      thr_q    <= 8'd0;
      sh_p1    <= 16'd0;
      res_rd   <= 1'b0;
      res_addr <= '0;
      out_wr   <= 1'b0;
      out_addr <= '0;
      out_do   <= 16'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nx;
      k        <= k_nx;
      word     <= word_nx;
      thr_q    <= thr_nx;
      sh_p1    <= sh_nx;
      res_rd   <= rd_nx;
      res_addr <= raddr_nx;
      out_wr   <= wr_nx;
      out_addr <= oaddr_nx;
      out_do   <= do_nx;
      busy     <= busy_nx;
      done     <= done_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_READ;
      S_READ:  if (k == LAST_K) state_nx = S_TAIL;
      S_TAIL:  state_nx = S_WRITE;
      S_WRITE: state_nx = (word == LAST_WORD) ? S_DONE : S_READ;
      S_DONE:  if (start) state_nx = S_READ;
      default: state_nx = S_IDLE;
    endcase
  end

  // Read data lags the strobe by one cycle, so each READ/TAIL cycle shifts in
  // the pixel requested one cycle earlier. The stale sample shifted in on k==0
  // falls off the top after all 16 pixels of the word have been captured.
  always_comb begin
    k_nx     = k;
    word_nx  = word;
    thr_nx   = thr_q;
    sh_nx    = sh_p1;
    rd_nx    = 1'b0;
    raddr_nx = res_addr;
    wr_nx    = 1'b0;
    oaddr_nx = out_addr;
    do_nx    = out_do;
    busy_nx  = busy;
    done_nx  = done;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          thr_nx   = thr;
          word_nx  = '0;
          k_nx     = 4'd0;
          rd_nx    = 1'b1;
          raddr_nx = '0;
          busy_nx  = 1'b1;
          done_nx  = 1'b0;
        end
      end
      S_READ: begin
        sh_nx = {sh_p1[14:0], hit_p0};
        if (k != LAST_K) begin
          rd_nx    = 1'b1;
          k_nx     = k + 4'd1;
          raddr_nx = res_addr + ADDR_ONE;
        end
      end
      S_TAIL: begin
        sh_nx    = {sh_p1[14:0], hit_p0};
        wr_nx    = 1'b1;
        oaddr_nx = word;
        do_nx    = {sh_p1[14:0], hit_p0};
      end
      S_WRITE: begin
        if (word == LAST_WORD) begin
          busy_nx = 1'b0;
          done_nx = 1'b1;
        end else begin
          word_nx  = word + {{(OADDR_W-1){1'b0}}, 1'b1};
          k_nx     = 4'd0;
          rd_nx    = 1'b1;
          raddr_nx = res_addr + ADDR_ONE;
        end
      end
      default: begin
        busy_nx = 1'b0;
        done_nx = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_dt_pack.sv
// Bench for dt_pack: res RAM model, per-word threshold model and directed passes.
module tb_dt_pack;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  thr;
  logic        res_rd;
  logic [13:0] res_addr;
  logic [7:0]  res_di;
  logic        out_wr;
  logic [9:0]  out_addr;
  logic [15:0] out_do;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem [16384];
  logic [7:0]  pass_thr;
  int          exp_word;
  int          exp_raddr;
  int          wr_cnt;
  logic [15:0] w0;

  dt_pack dut (
    .clk(clk), .reset(reset), .start(start), .thr(thr),
    .res_rd(res_rd), .res_addr(res_addr), .res_di(res_di),
    .out_wr(out_wr), .out_addr(out_addr), .out_do(out_do),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (res_rd) res_di <= mem[res_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model_word(input int w, input logic [7:0] t);
    logic [15:0] r;
    int te;
    te = (t == 8'd0) ? 1 : int'(t);
    for (int j = 0; j < 16; j++) r[15-j] = (int'(mem[w*16+j]) >= te);
    return r;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (res_rd) begin
        check("res_addr", {18'd0, res_addr}, exp_raddr);
        exp_raddr++;
      end
      if (out_wr) begin
        check("strobe_excl", {31'd0, res_rd}, 32'd0);
        check("out_addr", {22'd0, out_addr}, exp_word);
        check("out_do", {16'd0, out_do}, {16'd0, model_word(exp_word, pass_thr)});
        if (out_addr == 10'd0) w0 = out_do;
        exp_word++;
        wr_cnt++;
      end
    end
  end

  task automatic begin_pass(input logic [7:0] t);
    pass_thr  = t;
    exp_word  = 0;
    exp_raddr = 0;
    wr_cnt    = 0;
    @(negedge clk);
    start = 1'b1;
    thr   = t;
    @(negedge clk);
    start = 1'b0;
    thr   = 8'hA5;
    check("accept_busy", {31'd0, busy}, 32'd1);
    check("accept_done", {31'd0, done}, 32'd0);
    check("first_rd", {31'd0, res_rd}, 32'd1);
  endtask

  task automatic run_pass(input logic [7:0] t, input int poke);
    int cyc;
    begin_pass(t);
    cyc = 0;
    while (!done && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (cyc == poke) begin
        start = 1'b1;
        thr   = 8'd9;
      end else begin
        start = 1'b0;
      end
    end
    check("pass_len", cyc, 32'd18432);
    check("write_count", wr_cnt, 32'd1024);
    check("end_busy", {31'd0, busy}, 32'd0);
    check("end_rd", {31'd0, res_rd}, 32'd0);
    check("end_raddr", {18'd0, res_addr}, 32'd16383);
    check("end_oaddr", {22'd0, out_addr}, 32'd1023);
  endtask

  task automatic check_reset_outs(input string name);
    check(name, {res_rd, res_addr, out_wr, out_addr, out_do, busy, done}, 32'd0);
  endtask

  initial begin
    int n;
    logic [7:0] pix [16];
    pix = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd0, 8'd5, 8'd1, 8'd0,
            8'd4, 8'd4, 8'd0, 8'd0, 8'd9, 8'd1, 8'd2, 8'd0};
    for (int i = 0; i < 16384; i++) mem[i] = 8'd0;
    exp_word = 0; exp_raddr = 0; wr_cnt = 0; pass_thr = 8'd1; w0 = 16'hFFFF;
    reset = 1'b1; start = 1'b0; thr = 8'd0;
    repeat (3) @(negedge clk);
    check_reset_outs("reset_outs");
    reset = 1'b0;
    @(negedge clk);
    check_reset_outs("idle_outs");

    // All-zero map: every word must be zero.
    run_pass(8'd1, -1);
    check("zero_w0", {16'd0, w0}, 32'h0000);

    for (int j = 0; j < 16; j++) mem[j] = pix[j];
    mem[7*16+3] = 8'd3;
    mem[16383]  = 8'd200;

    // thr=2 with a stray start / thr=9 poke 100 cycles in.
    run_pass(8'd2, 100);
    check("w0_thr2", {16'd0, w0}, 32'h34CA);

    // Restart from DONE with thr=3.
    run_pass(8'd3, -1);
    check("w0_thr3", {16'd0, w0}, 32'h14C8);

    // Reset during the WRITE of word 5 aborts the pass.
    begin_pass(8'd1);
    n = 0;
    while (!(out_wr && out_addr == 10'd5) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("reach_w5", {31'd0, out_wr && out_addr == 10'd5}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outs("abort_outs");
    reset = 1'b0;

    // Fresh pass from IDLE with thr=0 behaves as thr=1.
    run_pass(8'd0, -1);
    check("w0_thr0", {16'd0, w0}, 32'h76CE);
    check("model_thr0", {16'd0, model_word(0, 8'd0)}, 32'h76CE);

    repeat (3) @(negedge clk);
    check("done_hold", {31'd0, done}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
